// File: rtl/i2c_master_byte.sv
// Byte-level I2C master: turns START/STOP/WRITE/READ commands into open-drain
// SCL/SDA levels, advancing one quarter-bit phase per divider tick.
module i2c_master_byte #(
    parameter int CMD_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CMD_W-1:0] cmd,
    input  logic [7:0]       wr_data,
    input  logic             ack_in,
    output logic [7:0]       rd_data,
    output logic             ack_out,
    output logic             done,
    output logic             busy,
    output logic             scl_o,
    output logic             sda_o,
    input  logic             sda_i
);

    localparam logic [CMD_W-1:0] CMD_START = CMD_W'(0);
    localparam logic [CMD_W-1:0] CMD_STOP  = CMD_W'(1);
    localparam logic [CMD_W-1:0] CMD_WRITE = CMD_W'(2);

    typedef enum logic [1:0] {S_IDLE, S_START, S_BIT, S_STOP} state_t;

    state_t      state;
    logic [1:0]  phase;
    logic [3:0]  bit_cnt;
    logic [7:0]  tx_sr;
    logic [7:0]  rx_sr;
    logic        is_read;
    logic        ack_bit;

    assign busy = ~cmd_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            phase     <= 2'd0;
            bit_cnt   <= 4'd0;
            tx_sr     <= 8'd0;
            rx_sr     <= 8'd0;
            is_read   <= 1'b0;
            ack_bit   <= 1'b1;
            cmd_ready <= 1'b1;
            done      <= 1'b0;
            rd_data   <= 8'd0;
            ack_out   <= 1'b1;
            scl_o     <= 1'b1;
            sda_o     <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // A tick on the accept edge is deliberately not consumed.
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        phase     <= 2'd0;
                        bit_cnt   <= 4'd0;
                        tx_sr     <= wr_data;
                        ack_bit   <= ack_in;
                        is_read   <= (cmd != CMD_WRITE);
                        if (cmd == CMD_START)     state <= S_START;
                        else if (cmd == CMD_STOP) state <= S_STOP;
                        else                      state <= S_BIT;
                    end
                end
                S_START: begin
                    if (tick) begin
                        phase <= phase + 2'd1;
                        case (phase)
                            2'd0: sda_o <= 1'b1;
                            2'd1: scl_o <= 1'b1;
                            2'd2: sda_o <= 1'b0;
                            default: begin
                                scl_o     <= 1'b0;
                                state     <= S_IDLE;
                                cmd_ready <= 1'b1;
                                done      <= 1'b1;
                            end
                        endcase
                    end
                end
                S_STOP: begin
                    if (tick) begin
                        phase <= phase + 2'd1;
                        case (phase)
                            2'd0: begin
                                scl_o <= 1'b0;
                                sda_o <= 1'b0;
                            end
                            2'd1: scl_o <= 1'b1;
                            2'd2: sda_o <= 1'b1;
                            default: begin
                                state     <= S_IDLE;
                                cmd_ready <= 1'b1;
                                done      <= 1'b1;
                            end
                        endcase
                    end
                end
                S_BIT: begin
                    if (tick) begin
                        phase <= phase + 2'd1;
                        case (phase)
                            2'd0: begin
                                scl_o <= 1'b0;
                                // Ninth bit is the ACK slot: released on WRITE, ack_in on READ.
                                if (bit_cnt == 4'd8) sda_o <= is_read ? ack_bit : 1'b1;
                                else                 sda_o <= is_read ? 1'b1 : tx_sr[7];
                            end
                            2'd1: scl_o <= 1'b1;
                            2'd2: begin
                                if (bit_cnt == 4'd8) begin
                                    if (!is_read) ack_out <= sda_i;
                                end else begin
                                    rx_sr <= {rx_sr[6:0], sda_i};
                                    tx_sr <= {tx_sr[6:0], 1'b0};
                                end
                            end
                            default: begin
                                scl_o <= 1'b0;
                                if (bit_cnt == 4'd8) begin
                                    bit_cnt   <= 4'd0;
                                    state     <= S_IDLE;
                                    cmd_ready <= 1'b1;
                                    done      <= 1'b1;
                                    if (is_read) rd_data <= rx_sr;
                                end else begin
                                    bit_cnt <= bit_cnt + 4'd1;
                                end
                            end
                        endcase
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
